usart_tx_ctrl: RTL and testbench

Transmit sequencer for the USART. It pops characters from the transmit-data FIFO (combinational-output mode) into a frame shifter and serialises them on TXD. Frames are start, 5–9 data bits LSB first, optional parity, and 1–2 stop bits, timed by an external bit-period tick. It generates the UDRE, TXC and busy status used by the register file and interrupt logic.

---
 rtl/usart_pkg.sv | 40 ++++
 rtl/usart_tx_ctrl.sv | 129 ++++++++++++
 tb/tb_usart_tx_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/usart_pkg.sv
// usart_pkg: shared state encoding, frame-format codes and char-size decode for the USART transmitter.
package usart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP1  = 3'd5;
    localparam logic [2:0] ST_STOP2  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP1  = ST_STOP1,
        S_STOP2  = ST_STOP2
    } state_t;

    localparam logic [2:0] UCSZ_5 = 3'b000;
    localparam logic [2:0] UCSZ_6 = 3'b001;
    localparam logic [2:0] UCSZ_7 = 3'b010;
    localparam logic [2:0] UCSZ_8 = 3'b011;
    localparam logic [2:0] UCSZ_9 = 3'b111;

    localparam logic [1:0] UPM_NONE = 2'b00;
    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    // Reserved codes 100/101/110 fall through to 8 bits.
    function automatic logic [3:0] char_size(input logic [2:0] ucsz);
        return (ucsz == UCSZ_5) ? 4'd5 :
               (ucsz == UCSZ_6) ? 4'd6 :
               (ucsz == UCSZ_7) ? 4'd7 :
               (ucsz == UCSZ_9) ? 4'd9 : 4'd8;
    endfunction

endpackage

// File: rtl/usart_tx_ctrl.sv
// usart_tx_ctrl: pops characters from the TX FIFO and serialises start/data/parity/stop on txd.
module usart_tx_ctrl
    import usart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BITCNT_W = 4
) (
    input  logic              cp2,
    input  logic              ireset,
    input  logic              bit_tick,
    input  logic              txen,
    input  logic [2:0]        ucsz,
    input  logic [1:0]        upm,
    input  logic              usbs,
    input  logic              txb8,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              fifo_re,
    input  logic              txc_clr,
    output logic              txd,
    output logic              txc,
    output logic              udre,
    output logic              tx_busy
);

    state_t              r_state, w_state_nx;
    logic [DATA_W:0]     r_shift, w_shift_nx;
    logic [BITCNT_W-1:0] r_cnt, w_cnt_nx, w_size;
    logic                r_par, w_par_nx;
    logic                r_txd, w_txd_nx;
    logic                r_txc, w_txc_nx;
    logic                w_can_pop, w_pop, w_eof;

    assign w_can_pop = txen & ~fifo_empty;
    assign w_size    = BITCNT_W'(char_size(ucsz));

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_par_nx   = r_par;
        w_txd_nx   = r_txd;
        w_pop      = 1'b0;
        w_eof      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bit_tick) begin
                    w_state_nx = S_START;
                    w_txd_nx   = 1'b0;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    w_state_nx = S_DATA;
                    w_txd_nx   = r_shift[0];
                    w_cnt_nx   = BITCNT_W'(1);
                    w_par_nx   = r_par ^ r_shift[0];
                end
            end
            S_DATA: begin
                if (bit_tick && r_cnt < w_size) begin
                    w_shift_nx = r_shift >> 1;
                    w_txd_nx   = r_shift[1];
                    w_par_nx   = r_par ^ r_shift[1];
                    w_cnt_nx   = r_cnt + BITCNT_W'(1);
                end else if (bit_tick) begin
                    w_state_nx = upm[1] ? S_PARITY : S_STOP1;
                    w_txd_nx   = 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    w_state_nx = S_STOP1;
                    w_txd_nx   = 1'b1;
                end
            end
            S_STOP1: begin
                if (bit_tick && usbs) w_state_nx = S_STOP2;
                else if (bit_tick) w_eof = 1'b1;
            end
            S_STOP2: w_eof = bit_tick;
            default: w_state_nx = S_IDLE;
        endcase
        // Chained frames reload straight into START, so no idle bit separates them.
        if (w_eof) begin
            w_pop      = w_can_pop;
            w_state_nx = w_can_pop ? S_START : S_IDLE;
            w_txd_nx   = ~w_can_pop;
        end
        if (w_pop) begin
            w_shift_nx = {txb8, fifo_dout};
            w_par_nx   = 1'b0;
        end
        w_txc_nx = (w_eof & ~w_can_pop) ? 1'b1 :
                   (txc_clr | (w_pop & (r_state == S_IDLE))) ? 1'b0 : r_txc;
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_txc   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
            r_par   <= w_par_nx;
            r_txd   <= w_txd_nx;
            r_txc   <= w_txc_nx;
        end
    end

    assign fifo_re = w_pop & ireset;
    assign txd     = (r_state == S_PARITY) ? (r_par ^ upm[0]) : r_txd;
    assign txc     = r_txc;
    assign udre    = txen & ~fifo_full;
    assign tx_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_usart_tx_ctrl.sv
// tb_usart_tx_ctrl: directed frame checks for usart_tx_ctrl against a small bench-side FIFO.
module tb_usart_tx_ctrl;

    logic       cp2 = 1'b0, ireset = 1'b0, bit_tick = 1'b0, txen = 1'b0;
    logic       usbs = 1'b0, txb8 = 1'b0, txc_clr = 1'b0;
    logic [2:0] ucsz = 3'b011;
    logic [1:0] upm = 2'b00;
    logic [7:0] fifo_dout;
    logic       fifo_empty, fifo_full, fifo_re, txd, txc, udre, tx_busy;
    logic [7:0] mem [0:3];
    int         rd = 0, wr = 0, pops = 0, n_cmp = 0, n_err = 0;

    usart_tx_ctrl #(.DATA_W(8), .BITCNT_W(4)) dut (
        .cp2(cp2), .ireset(ireset), .bit_tick(bit_tick), .txen(txen),
        .ucsz(ucsz), .upm(upm), .usbs(usbs), .txb8(txb8),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_re(fifo_re), .txc_clr(txc_clr), .txd(txd), .txc(txc),
        .udre(udre), .tx_busy(tx_busy)
    );

    always #5 cp2 = ~cp2;

    assign fifo_empty = (rd == wr);
    assign fifo_full  = ((wr - rd) == 4);
    assign fifo_dout  = mem[rd[1:0]];

    always @(posedge cp2) begin
        if (fifo_re) begin
            rd   <= rd + 1;
            pops <= pops + 1;
        end
    end

    task cyc();
        @(posedge cp2);
        #1;
    endtask

    task tick_bit(input logic clr);
        repeat (3) cyc();
        bit_tick = 1'b1;
        txc_clr  = clr;
        cyc();
        bit_tick = 1'b0;
        txc_clr  = 1'b0;
    endtask

    task push(input logic [7:0] d);
        mem[wr[1:0]] = d;
        wr++;
    endtask

    task automatic test_reset();
        txen = 1'b1;
        push(8'h11);
        repeat (2) cyc();
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (txc !== 1'b0) begin n_err++; $display("FAIL reset_txc: got %b want 0", txc); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_cmp++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL reset_fifo_re: got %b want 0", fifo_re); end
        txen = 1'b0;
        wr = rd;
        ireset = 1'b1;
        cyc();
    endtask

    task automatic test_8n1();
        logic [10:0] exp = {3'b111, 8'hA5, 1'b0};
        int p0 = pops;
        ucsz = 3'b011; upm = 2'b00; usbs = 1'b0; txen = 1'b1;
        push(8'hA5);
        cyc();
        n_cmp++; if (tx_busy !== 1'b1 || txd !== 1'b1) begin n_err++; $display("FAIL 8n1_wait: busy=%b txd=%b want 1 1", tx_busy, txd); end
        for (int i = 0; i < 11; i++) begin
            tick_bit(1'b0);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL 8n1_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
            n_cmp++; if (txc !== (i == 10)) begin n_err++; $display("FAIL 8n1_txc tick %0d: got %b want %b", i + 1, txc, i == 10); end
        end
        n_cmp++; if (pops - p0 !== 1) begin n_err++; $display("FAIL 8n1_pops: got %0d want 1", pops - p0); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL 8n1_idle: busy=%b want 0", tx_busy); end
    endtask

    task automatic test_8e2();
        logic [12:0] exp = {4'b1111, 1'b0, 8'hA5, 1'b0};
        upm = 2'b10; usbs = 1'b1;
        push(8'hA5);
        cyc();
        n_cmp++; if (txc !== 1'b0) begin n_err++; $display("FAIL 8e2_pop_clears_txc: got %b want 0", txc); end
        for (int i = 0; i < 13; i++) begin
            tick_bit(1'b0);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL 8e2_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
            n_cmp++; if (txc !== (i == 12)) begin n_err++; $display("FAIL 8e2_txc tick %0d: got %b want %b", i + 1, txc, i == 12); end
        end
    endtask

    task automatic test_8o1();
        logic [11:0] exp = {3'b111, 1'b0, 8'h07, 1'b0};
        upm = 2'b11; usbs = 1'b0;
        push(8'h07);
        cyc();
        for (int i = 0; i < 12; i++) begin
            tick_bit(1'b0);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL 8o1_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
        end
        n_cmp++; if (txc !== 1'b1) begin n_err++; $display("FAIL 8o1_txc: got %b want 1", txc); end
    endtask

    task automatic test_9n1();
        logic [12:0] exp = {3'b111, 9'h13C, 1'b0};
        ucsz = 3'b111; upm = 2'b00; txb8 = 1'b1;
        push(8'h3C);
        cyc();
        txb8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick_bit(1'b0);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL 9n1_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
        end
        ucsz = 3'b011;
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp = {2'b11, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
        int p0 = pops;
        push(8'h55);
        push(8'hAA);
        cyc();
        for (int i = 0; i < 21; i++) begin
            tick_bit(1'b0);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL b2b_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
            n_cmp++; if (txc !== (i == 20)) begin n_err++; $display("FAIL b2b_txc tick %0d: got %b want %b", i + 1, txc, i == 20); end
        end
        n_cmp++; if (pops - p0 !== 2) begin n_err++; $display("FAIL b2b_pops: got %0d want 2", pops - p0); end
    endtask

    task automatic test_txen_drop();
        logic [10:0] exp = {3'b111, 8'h55, 1'b0};
        int p0 = pops;
        push(8'h55);
        push(8'h66);
        cyc();
        for (int i = 0; i < 11; i++) begin
            if (i == 3) txen = 1'b0;
            tick_bit(i == 10);
            n_cmp++; if (txd !== exp[i]) begin n_err++; $display("FAIL drop_txd tick %0d: got %b want %b", i + 1, txd, exp[i]); end
        end
        repeat (4) cyc();
        n_cmp++; if (txc !== 1'b1) begin n_err++; $display("FAIL drop_txc_set_wins: got %b want 1", txc); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: busy=%b want 0", tx_busy); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL drop_fifo_kept: empty=%b want 0", fifo_empty); end
        n_cmp++; if (pops - p0 !== 1) begin n_err++; $display("FAIL drop_pops: got %0d want 1", pops - p0); end
        txc_clr = 1'b1;
        cyc();
        txc_clr = 1'b0;
        n_cmp++; if (txc !== 1'b0) begin n_err++; $display("FAIL txc_clr: got %b want 0", txc); end
        wr = rd;
    endtask

    task automatic test_reset_midframe();
        txen = 1'b1;
        push(8'h81);
        cyc();
        repeat (3) tick_bit(1'b0);
        n_cmp++; if (txd !== 1'b0 || tx_busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: txd=%b busy=%b want 0 1", txd, tx_busy); end
        #2 ireset = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL mid_rst_txd: got %b want 1", txd); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", tx_busy); end
        n_cmp++; if (txc !== 1'b0 || fifo_re !== 1'b0) begin n_err++; $display("FAIL mid_rst_txc_re: txc=%b re=%b want 0 0", txc, fifo_re); end
        cyc();
        ireset = 1'b1;
        repeat (2) tick_bit(1'b0);
        n_cmp++; if (tx_busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL mid_after: busy=%b txd=%b want 0 1", tx_busy, txd); end
    endtask

    task automatic test_idle_udre();
        tick_bit(1'b0);
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL idle_tick: busy=%b want 0", tx_busy); end
        n_cmp++; if (udre !== 1'b1) begin n_err++; $display("FAIL udre_on: got %b want 1", udre); end
        txen = 1'b0;
        repeat (4) push(8'h00);
        #1;
        n_cmp++; if (udre !== 1'b0) begin n_err++; $display("FAIL udre_txen_off: got %b want 0", udre); end
        txen = 1'b1;
        #1;
        n_cmp++; if (udre !== 1'b0) begin n_err++; $display("FAIL udre_full: got %b want 0", udre); end
        txen = 1'b0;
        wr = rd;
        cyc();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_8e2();
        test_8o1();
        test_9n1();
        test_back_to_back();
        test_txen_drop();
        test_reset_midframe();
        test_idle_udre();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
